// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter: shares the register file's single write port
// between N_REQ requesters, with a registered one-cycle-latency write stage.
module rf_wb_arbiter #(
    parameter int unsigned N_REQ = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    i_req_valid,
    input  logic [5*N_REQ-1:0]  i_req_rd,
    input  logic [32*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]    o_req_ready,
    input  logic                i_wb_en,
    input  logic                i_flush,
    output logic                o_wr,
    output logic [4:0]          o_rd,
    output logic [31:0]         o_write_data,
    output logic [2:0]          o_grant_id,
    output logic                o_busy
);

    localparam int unsigned PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic             r_wr;
    logic [4:0]       r_rd;
    logic [31:0]      r_data;
    logic [2:0]       r_gid;

    logic [7:0]       w_valid_ext;
    logic [2:0]       w_idx;
    logic [2:0]       w_gnt_idx;
    logic             w_found;
    logic             w_grant;
    logic [N_REQ-1:0] w_ready;
    logic [4:0]       w_sel_rd;
    logic [31:0]      w_sel_data;
    logic [PTR_W-1:0] w_ptr_nxt;

    assign w_valid_ext = 8'(i_req_valid);

    // Reset gating keeps ready low while rst_n is asserted, whatever the inputs.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = 3'd0;
        w_idx     = 3'd0;
        w_ready   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(r_ptr) + i >= N_REQ) begin
                w_idx = 3'(32'(r_ptr) + i - N_REQ);
            end else begin
                w_idx = 3'(32'(r_ptr) + i);
            end
            if (!w_found && w_valid_ext[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
        w_grant = w_found & i_wb_en & ~i_flush & rst_n;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_grant && (w_gnt_idx == 3'(k))) begin
                w_ready[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_rd   = 5'd0;
        w_sel_data = 32'd0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_ready[k]) begin
                w_sel_rd   = i_req_rd[5*k +: 5];
                w_sel_data = i_req_data[32*k +: 32];
            end
        end
        if (w_gnt_idx == 3'(N_REQ - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = PTR_W'(w_gnt_idx + 3'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_wr   <= 1'b0;
            r_rd   <= 5'd0;
            r_data <= 32'd0;
            r_gid  <= 3'd0;
        end else begin
            r_wr <= 1'b0;
            if (w_grant) begin
                r_ptr  <= w_ptr_nxt;
                r_rd   <= w_sel_rd;
                r_data <= w_sel_data;
                r_gid  <= w_gnt_idx;
                // x0 writes are consumed but never reach the register file.
                r_wr   <= (w_sel_rd != 5'd0);
            end
        end
    end

    assign o_req_ready  = w_ready;
    assign o_wr         = r_wr;
    assign o_rd         = r_rd;
    assign o_write_data = r_data;
    assign o_grant_id   = r_gid;
    assign o_busy       = |i_req_valid;

endmodule
